// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the integer writeback port arbiter.
// Writeback payload layout and default writeback port count.
package wb_port_arbiter_pkg;

    localparam int WBPORT_NUM = 2;

    typedef logic [5:0] robIdx_t;
    typedef logic [3:0] irobIdx_t;
    typedef logic [6:0] iprIdx_t;

    typedef struct packed {
        logic           rd_wen;
        iprIdx_t        iprd;
        robIdx_t        rob_idx;
        irobIdx_t       irob_idx;
        logic [63:0]    result;
    } valwbInfo_t;

    // (a + b) mod n, valid for a < n and b <= n; works for any n.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_select.sv
// Round-robin select of up to M occupied slots out of N, scanning from ptr.
// Purely combinational; the k-th winner in scan order lands on port k.
module rr_multi_select
    import wb_port_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int M  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]         occ,
    input  logic [PW-1:0]        ptr,
    output logic [N-1:0]         grant,
    output logic [M-1:0][PW-1:0] port_idx,
    output logic [M-1:0]         port_vld,
    output logic [PW-1:0]        next_ptr
);

    int idx;
    int cnt;

    // Scan ptr, ptr+1, ... mod N and grant the first M occupied slots.
    always_comb begin
        grant    = '0;
        port_idx = '0;
        port_vld = '0;
        next_ptr = ptr;
        idx      = 0;
        cnt      = 0;
        for (int i = 0; i < N; i++) begin
            idx = wrap_add(int'(ptr), i, N);
            if (occ[idx] && (cnt < M)) begin
                grant[idx]    = 1'b1;
                port_vld[cnt] = 1'b1;
                port_idx[cnt] = PW'(idx);
                next_ptr      = PW'(wrap_add(idx, 1, N));
                cnt           = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares NUM_PORT int writeback ports among NUM_REQ FU requesters.
// Optional WB_PORT_ARBITER_PERF_EN adds a saturating contention counter.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int NUM_PORT = WBPORT_NUM
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic [NUM_REQ-1:0]           i_req_vld,
    output logic [NUM_REQ-1:0]           o_req_rdy,
    input  valwbInfo_t [NUM_REQ-1:0]     i_req_info,
`ifdef WB_PORT_ARBITER_PERF_EN
    output logic [31:0]                  o_conflict_cnt,
`endif
    output logic [NUM_PORT-1:0]          o_wb_vld,
    output valwbInfo_t [NUM_PORT-1:0]    o_wb_info
);

    localparam int PW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           buf_vld;
    valwbInfo_t                   buf_info [NUM_REQ];
    logic [PW-1:0]                rr_ptr;
    logic [NUM_REQ-1:0]           grant;
    logic [NUM_PORT-1:0][PW-1:0]  port_idx;
    logic [NUM_PORT-1:0]          port_vld;
    logic [PW-1:0]                next_ptr;

    rr_multi_select #(
        .N  (NUM_REQ),
        .M  (NUM_PORT),
        .PW (PW)
    ) u_sel (
        .occ      (buf_vld),
        .ptr      (rr_ptr),
        .grant    (grant),
        .port_idx (port_idx),
        .port_vld (port_vld),
        .next_ptr (next_ptr)
    );

    // A buffer accepts when empty or draining this cycle; squash blocks entry.
    always_comb begin
        o_req_rdy = (~buf_vld | grant) & {NUM_REQ{~i_flush}};
    end

    // Holding buffers, round-robin pointer and registered writeback ports.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_vld   <= '0;
            rr_ptr    <= '0;
            o_wb_vld  <= '0;
            o_wb_info <= '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                buf_info[r] <= '0;
            end
        end else if (i_flush) begin
            buf_vld  <= '0;
            o_wb_vld <= '0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (i_req_vld[r] && o_req_rdy[r]) begin
                    buf_vld[r]  <= 1'b1;
                    buf_info[r] <= i_req_info[r];
                end else if (grant[r]) begin
                    buf_vld[r] <= 1'b0;
                end
            end
            if (|grant) begin
                rr_ptr <= next_ptr;
            end
            o_wb_vld <= port_vld;
            for (int p = 0; p < NUM_PORT; p++) begin
                if (port_vld[p]) begin
                    o_wb_info[p] <= buf_info[port_idx[p]];
                end
            end
        end
    end

`ifdef WB_PORT_ARBITER_PERF_EN
    logic [31:0] conflict_cnt;

    assign o_conflict_cnt = conflict_cnt;

    // Count cycles with more pending writebacks than ports; survives flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt <= '0;
        end else if (($countones(buf_vld) > NUM_PORT) && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with NUM_REQ=4, NUM_PORT=2.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             i_flush;
    logic [3:0]       i_req_vld;
    logic [3:0]       o_req_rdy;
    valwbInfo_t [3:0] i_req_info;
    logic [1:0]       o_wb_vld;
    valwbInfo_t [1:0] o_wb_info;
`ifdef WB_PORT_ARBITER_PERF_EN
    logic [31:0]      o_conflict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(.NUM_REQ(4), .NUM_PORT(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (i_flush),
        .i_req_vld  (i_req_vld),
        .o_req_rdy  (o_req_rdy),
        .i_req_info (i_req_info),
`ifdef WB_PORT_ARBITER_PERF_EN
        .o_conflict_cnt (o_conflict_cnt),
`endif
        .o_wb_vld   (o_wb_vld),
        .o_wb_info  (o_wb_info)
    );

    always #5 clk = ~clk;

    function automatic valwbInfo_t mk(input int rob, input int iprd,
                                      input logic [63:0] res, input logic wen);
        valwbInfo_t v;
        v.rd_wen   = wen;
        v.iprd     = iprIdx_t'(iprd);
        v.rob_idx  = robIdx_t'(rob);
        v.irob_idx = irobIdx_t'(rob);
        v.result   = res;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        i_flush    = 1'b0;
        i_req_vld  = '0;
        i_req_info = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (o_wb_vld !== 2'b00) begin
            errors++;
            $display("FAIL reset_wb_vld: got %b exp 00", o_wb_vld);
        end
        checks++;
        if (o_req_rdy !== 4'b1111) begin
            errors++;
            $display("FAIL reset_rdy: got %b exp 1111", o_req_rdy);
        end
        checks++;
        if (o_wb_info !== '0) begin
            errors++;
            $display("FAIL reset_info: got %h exp 0", o_wb_info);
        end
        checks++;
        if (dut.rr_ptr !== 2'd0) begin
            errors++;
            $display("FAIL reset_ptr: got %0d exp 0", dut.rr_ptr);
        end
    endtask

    task automatic test_single();
        valwbInfo_t a, b, c;
        a = mk(5, 12, 64'hDEAD, 1'b1);
        b = mk(6, 13, 64'hBEEF, 1'b1);
        c = mk(7, 14, 64'hCAFE, 1'b1);
        do_reset();
        i_req_info[1] = a;
        i_req_vld     = 4'b0010;
        step();
        i_req_info[1] = b;
        #1;
        checks++;
        if (o_req_rdy[1] !== 1'b1 || o_wb_vld !== 2'b00) begin
            errors++;
            $display("FAIL single_e0: rdy1=%b vld=%b exp rdy1=1 vld=00",
                     o_req_rdy[1], o_wb_vld);
        end
        step();
        checks++;
        if (o_wb_vld !== 2'b01 || o_wb_info[0] !== a) begin
            errors++;
            $display("FAIL single_first: vld=%b info=%h exp 01 %h",
                     o_wb_vld, o_wb_info[0], a);
        end
        i_req_info[1] = c;
        #1;
        checks++;
        if (o_req_rdy[1] !== 1'b1) begin
            errors++;
            $display("FAIL single_rdy_b2b: got %b exp 1", o_req_rdy[1]);
        end
        step();
        i_req_vld = '0;
        checks++;
        if (o_wb_vld !== 2'b01 || o_wb_info[0] !== b) begin
            errors++;
            $display("FAIL single_second: vld=%b info=%h exp 01 %h",
                     o_wb_vld, o_wb_info[0], b);
        end
        step();
        checks++;
        if (o_wb_vld !== 2'b01 || o_wb_info[0] !== c) begin
            errors++;
            $display("FAIL single_third: vld=%b info=%h exp 01 %h",
                     o_wb_vld, o_wb_info[0], c);
        end
        step();
        checks++;
        if (o_wb_vld !== 2'b00) begin
            errors++;
            $display("FAIL single_idle: got %b exp 00", o_wb_vld);
        end
    endtask

    task automatic test_contention();
        valwbInfo_t e [4];
        for (int r = 0; r < 4; r++) begin
            e[r] = mk(r + 8, r + 40, 64'h1000 + 64'(r), (r != 3));
        end
        do_reset();
        for (int r = 0; r < 4; r++) begin
            i_req_info[r] = e[r];
        end
        i_req_vld = 4'b1111;
        step();
        i_req_vld = '0;
        #1;
        checks++;
        if (o_req_rdy !== 4'b0011) begin
            errors++;
            $display("FAIL cont_rdy0: got %b exp 0011", o_req_rdy);
        end
        step();
        checks++;
        if (o_wb_vld !== 2'b11 || o_wb_info[0] !== e[0] || o_wb_info[1] !== e[1]) begin
            errors++;
            $display("FAIL cont_cyc1: vld=%b p0=%h p1=%h", o_wb_vld,
                     o_wb_info[0], o_wb_info[1]);
        end
        checks++;
        if (o_req_rdy !== 4'b1111) begin
            errors++;
            $display("FAIL cont_rdy1: got %b exp 1111", o_req_rdy);
        end
        step();
        checks++;
        if (o_wb_vld !== 2'b11 || o_wb_info[0] !== e[2] || o_wb_info[1] !== e[3]) begin
            errors++;
            $display("FAIL cont_cyc2: vld=%b p0=%h p1=%h", o_wb_vld,
                     o_wb_info[0], o_wb_info[1]);
        end
        checks++;
        if (dut.rr_ptr !== 2'd0) begin
            errors++;
            $display("FAIL cont_ptr: got %0d exp 0", dut.rr_ptr);
        end
        step();
        checks++;
        if (o_wb_vld !== 2'b00) begin
            errors++;
            $display("FAIL cont_idle: got %b exp 00", o_wb_vld);
        end
    endtask

    task automatic test_wrap();
        valwbInfo_t r2, n0, n3;
        r2 = mk(2, 22, 64'h22, 1'b1);
        n0 = mk(30, 50, 64'h30, 1'b1);
        n3 = mk(33, 53, 64'h33, 1'b0);
        do_reset();
        i_req_info[0] = mk(0, 20, 64'h20, 1'b1);
        i_req_info[1] = mk(1, 21, 64'h21, 1'b1);
        i_req_info[2] = r2;
        i_req_vld     = 4'b0111;
        step();
        i_req_vld = '0;
        step();
        i_req_info[0] = n0;
        i_req_info[3] = n3;
        i_req_vld     = 4'b1001;
        step();
        i_req_vld = '0;
        checks++;
        if (dut.rr_ptr !== 2'd3 || o_wb_vld !== 2'b01 || o_wb_info[0] !== r2) begin
            errors++;
            $display("FAIL wrap_setup: ptr=%0d vld=%b p0=%h exp 3 01 %h",
                     dut.rr_ptr, o_wb_vld, o_wb_info[0], r2);
        end
        step();
        checks++;
        if (o_wb_vld !== 2'b11 || o_wb_info[0] !== n3 || o_wb_info[1] !== n0) begin
            errors++;
            $display("FAIL wrap_ports: vld=%b p0=%h p1=%h", o_wb_vld,
                     o_wb_info[0], o_wb_info[1]);
        end
        checks++;
        if (dut.rr_ptr !== 2'd1) begin
            errors++;
            $display("FAIL wrap_ptr: got %0d exp 1", dut.rr_ptr);
        end
    endtask

    task automatic test_flush();
        do_reset();
        i_req_info[1] = mk(1, 61, 64'h61, 1'b1);
        i_req_vld     = 4'b0010;
        step();
        i_req_info[0] = mk(0, 60, 64'h60, 1'b1);
        i_req_info[2] = mk(2, 62, 64'h62, 1'b1);
        i_req_vld     = 4'b0101;
        step();
        checks++;
        if (o_wb_vld !== 2'b01 || dut.buf_vld !== 4'b0101) begin
            errors++;
            $display("FAIL flush_setup: vld=%b buf=%b exp 01 0101",
                     o_wb_vld, dut.buf_vld);
        end
        i_flush       = 1'b1;
        i_req_info[1] = mk(9, 63, 64'h63, 1'b1);
        i_req_vld     = 4'b0010;
        #1;
        checks++;
        if (o_req_rdy !== 4'b0000) begin
            errors++;
            $display("FAIL flush_rdy: got %b exp 0000", o_req_rdy);
        end
        step();
        i_flush   = 1'b0;
        i_req_vld = '0;
        checks++;
        if (o_wb_vld !== 2'b00 || dut.buf_vld !== 4'b0000) begin
            errors++;
            $display("FAIL flush_clear: vld=%b buf=%b exp 00 0000",
                     o_wb_vld, dut.buf_vld);
        end
        checks++;
        if (dut.rr_ptr !== 2'd2) begin
            errors++;
            $display("FAIL flush_ptr: got %0d exp 2", dut.rr_ptr);
        end
        step();
        checks++;
        if (o_wb_vld !== 2'b00) begin
            errors++;
            $display("FAIL flush_discard: got %b exp 00", o_wb_vld);
        end
    endtask

    task automatic test_async_reset();
        valwbInfo_t e [4];
        for (int r = 0; r < 4; r++) begin
            e[r] = mk(r + 16, r + 70, 64'h7000 + 64'(r), 1'b1);
        end
        do_reset();
        for (int r = 0; r < 4; r++) begin
            i_req_info[r] = e[r];
        end
        i_req_vld = 4'b0111;
        step();
        step();
        i_req_vld = '0;
        checks++;
        if (o_wb_vld !== 2'b11 || dut.buf_vld !== 4'b0111) begin
            errors++;
            $display("FAIL areset_setup: vld=%b buf=%b exp 11 0111",
                     o_wb_vld, dut.buf_vld);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (o_wb_vld !== 2'b00 || dut.buf_vld !== 4'b0000 || dut.rr_ptr !== 2'd0) begin
            errors++;
            $display("FAIL areset_now: vld=%b buf=%b ptr=%0d exp 00 0000 0",
                     o_wb_vld, dut.buf_vld, dut.rr_ptr);
        end
        rst       = 1'b1;
        i_req_vld = 4'b1111;
        step();
        i_req_vld = '0;
        step();
        checks++;
        if (o_wb_vld !== 2'b11 || o_wb_info[0] !== e[0] || o_wb_info[1] !== e[1]) begin
            errors++;
            $display("FAIL areset_restart: vld=%b p0=%h p1=%h", o_wb_vld,
                     o_wb_info[0], o_wb_info[1]);
        end
    endtask

`ifdef WB_PORT_ARBITER_PERF_EN
    task automatic test_perf();
        do_reset();
        for (int r = 0; r < 3; r++) begin
            i_req_info[r] = mk(r, r, 64'(r), 1'b1);
        end
        i_req_vld = 4'b0111;
        step();
        repeat (5) step();
        checks++;
        if (o_conflict_cnt !== 32'd5) begin
            errors++;
            $display("FAIL perf_cnt: got %0d exp 5", o_conflict_cnt);
        end
        i_flush   = 1'b1;
        i_req_vld = '0;
        step();
        i_flush = 1'b0;
        step();
        checks++;
        if (o_conflict_cnt !== 32'd6) begin
            errors++;
            $display("FAIL perf_flush: got %0d exp 6", o_conflict_cnt);
        end
    endtask
`endif

    initial begin
        i_flush    = 1'b0;
        i_req_vld  = '0;
        i_req_info = '0;
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_flush();
        test_async_reset();
`ifdef WB_PORT_ARBITER_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
